// File: rtl/htif_mem_initiator.sv
// Host-side HTIF memory requester: tags requests by reorder slot and returns results in command order.
// Latency: accept -> htif_req_val +1 cycle; response -> rsp_val +1 cycle.
// Backpressure: cmd_rdy drops when the ROB is full or the issue register is stalled; rsp held until rsp_rdy.
module htif_mem_initiator #(
    parameter int DEPTH    = 4,
    parameter int TAG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_val,
    output logic                cmd_rdy,
    input  logic                cmd_rw,
    input  logic [13:0]         cmd_addr,
    input  logic [127:0]        cmd_data,
    output logic                rsp_val,
    input  logic                rsp_rdy,
    output logic                rsp_rw,
    output logic [127:0]        rsp_data,
    output logic                htif_req_val,
    input  logic                htif_req_rdy,
    output logic                htif_req_rw,
    output logic [13:0]         htif_req_addr,
    output logic [127:0]        htif_req_data,
    output logic [TAG_BITS-1:0] htif_req_tag,
    input  logic                htif_resp_val,
    input  logic [127:0]        htif_resp_data,
    input  logic [TAG_BITS-1:0] htif_resp_tag,
    output logic                proto_err
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUING,
        S_PENDING,
        S_DONE
    } slot_state_t;

    slot_state_t         slot_q [DEPTH];
    slot_state_t         slot_d [DEPTH];
    logic                slot_rw_q [DEPTH];
    logic [127:0]        slot_data_q [DEPTH];

    logic [PTR_BITS-1:0] head_q;
    logic [PTR_BITS-1:0] tail_q;
    logic [CNT_BITS-1:0] count_q;
    logic                live_q;

    logic                iss_val_q;
    logic                iss_rw_q;
    logic [13:0]         iss_addr_q;
    logic [127:0]        iss_data_q;
    logic [PTR_BITS-1:0] iss_tag_q;
    logic                proto_err_q;

    logic                cmd_acc;
    logic                req_fire;
    logic                pop;
    logic                resp_hi_zero;
    logic                resp_ok;
    logic                resp_bad;
    logic [PTR_BITS-1:0] resp_slot;

    // live_q keeps cmd_rdy low while reset is held without a combinational path from reset
    assign cmd_rdy  = live_q && (count_q < CNT_BITS'(DEPTH)) && (!iss_val_q || htif_req_rdy);
    assign cmd_acc  = cmd_val && cmd_rdy;
    assign req_fire = iss_val_q && htif_req_rdy;

    assign rsp_val  = (slot_q[head_q] == S_DONE);
    assign rsp_rw   = rsp_val && slot_rw_q[head_q];
    assign rsp_data = rsp_val ? slot_data_q[head_q] : '0;
    assign pop      = rsp_val && rsp_rdy;

    assign resp_slot    = htif_resp_tag[PTR_BITS-1:0];
    assign resp_hi_zero = ((htif_resp_tag >> PTR_BITS) == '0);
    assign resp_ok      = htif_resp_val && resp_hi_zero && (slot_q[resp_slot] == S_PENDING);
    assign resp_bad     = htif_resp_val && !resp_ok;

    assign htif_req_val  = iss_val_q;
    assign htif_req_rw   = iss_rw_q;
    assign htif_req_addr = iss_addr_q;
    assign htif_req_data = iss_data_q;
    assign htif_req_tag  = TAG_BITS'(iss_tag_q);
    assign proto_err     = proto_err_q;

    // Each event targets a slot in a distinct state, so at most one of these fires per slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
            if (cmd_acc && tail_q == PTR_BITS'(i))
                slot_d[i] = S_ISSUING;
            if (req_fire && iss_tag_q == PTR_BITS'(i))
                slot_d[i] = iss_rw_q ? S_DONE : S_PENDING;
            if (resp_ok && resp_slot == PTR_BITS'(i))
                slot_d[i] = S_DONE;
            if (pop && head_q == PTR_BITS'(i))
                slot_d[i] = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                slot_q[i] <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            live_q      <= 1'b0;
            iss_val_q   <= 1'b0;
            iss_rw_q    <= 1'b0;
            iss_addr_q  <= '0;
            iss_data_q  <= '0;
            iss_tag_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                slot_q[i] <= slot_d[i];
            live_q  <= 1'b1;
            count_q <= count_q + CNT_BITS'(cmd_acc) - CNT_BITS'(pop);
            if (cmd_acc)
                tail_q <= tail_q + PTR_BITS'(1);
            if (pop)
                head_q <= head_q + PTR_BITS'(1);
            if (cmd_acc) begin
                iss_val_q  <= 1'b1;
                iss_rw_q   <= cmd_rw;
                iss_addr_q <= cmd_addr;
                iss_data_q <= cmd_data;
                iss_tag_q  <= tail_q;
            end else if (req_fire) begin
                iss_val_q <= 1'b0;
            end
            if (resp_bad)
                proto_err_q <= 1'b1;
        end
    end

    // Payload storage needs no reset: it is only observed once the slot reaches DONE.
    always_ff @(posedge clk) begin
        if (cmd_acc) begin
            slot_rw_q[tail_q]   <= cmd_rw;
            slot_data_q[tail_q] <= '0;
        end
        if (resp_ok)
            slot_data_q[resp_slot] <= htif_resp_data;
    end

endmodule

// File: tb/tb_htif_mem_initiator.sv
// Directed bench for htif_mem_initiator: a per-cycle vector table plus hand-written corner-case sequences.
module tb_htif_mem_initiator;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] Z  = 128'h0;

    logic         clk;
    logic         reset;
    logic         cmd_val, cmd_rdy, cmd_rw;
    logic [13:0]  cmd_addr;
    logic [127:0] cmd_data;
    logic         rsp_val, rsp_rdy, rsp_rw;
    logic [127:0] rsp_data;
    logic         htif_req_val, htif_req_rdy, htif_req_rw;
    logic [13:0]  htif_req_addr;
    logic [127:0] htif_req_data;
    logic [4:0]   htif_req_tag;
    logic         htif_resp_val;
    logic [127:0] htif_resp_data;
    logic [4:0]   htif_resp_tag;
    logic         proto_err;

    int n_vec;
    int n_fail;

    htif_mem_initiator #(.DEPTH(4), .TAG_BITS(5)) dut (
        .clk(clk), .reset(reset),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_rw(rsp_rw), .rsp_data(rsp_data),
        .htif_req_val(htif_req_val), .htif_req_rdy(htif_req_rdy), .htif_req_rw(htif_req_rw),
        .htif_req_addr(htif_req_addr), .htif_req_data(htif_req_data), .htif_req_tag(htif_req_tag),
        .htif_resp_val(htif_resp_val), .htif_resp_data(htif_resp_data), .htif_resp_tag(htif_resp_tag),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         pre_rst;
        logic         cv;
        logic         crw;
        logic [13:0]  ca;
        logic [127:0] cd;
        logic         qrdy;
        logic         rv;
        logic [4:0]   rt;
        logic [127:0] rd;
        logic         prdy;
        logic         e_crdy;
        logic         e_qv;
        logic         e_qrw;
        logic [13:0]  e_qa;
        logic [127:0] e_qd;
        logic [4:0]   e_qt;
        logic         e_pv;
        logic         e_prw;
        logic [127:0] e_pd;
        logic         e_perr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic pre_rst, input logic cv, input logic crw, input logic [13:0] ca,
        input logic [127:0] cd, input logic qrdy, input logic rv, input logic [4:0] rt,
        input logic [127:0] rd, input logic prdy, input logic e_crdy, input logic e_qv,
        input logic e_qrw, input logic [13:0] e_qa, input logic [127:0] e_qd,
        input logic [4:0] e_qt, input logic e_pv, input logic e_prw,
        input logic [127:0] e_pd, input logic e_perr);
        vec_t v;
        v.pre_rst = pre_rst; v.cv = cv; v.crw = crw; v.ca = ca; v.cd = cd;
        v.qrdy = qrdy; v.rv = rv; v.rt = rt; v.rd = rd; v.prdy = prdy;
        v.e_crdy = e_crdy; v.e_qv = e_qv; v.e_qrw = e_qrw; v.e_qa = e_qa; v.e_qd = e_qd;
        v.e_qt = e_qt; v.e_pv = e_pv; v.e_prw = e_prw; v.e_pd = e_pd; v.e_perr = e_perr;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        cmd_val = L; cmd_rw = L; cmd_addr = 14'h0; cmd_data = Z;
        htif_req_rdy = H; rsp_rdy = L;
        htif_resp_val = L; htif_resp_tag = 5'd0; htif_resp_data = Z;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 with reset released and the block ready to accept.
    task automatic do_reset();
        reset = H;
        set_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = L;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, " cmd_rdy"}, cmd_rdy, L);
        chk1({tag, " rsp_val"}, rsp_val, L);
        chk1({tag, " rsp_rw"}, rsp_rw, L);
        chkw({tag, " rsp_data"}, rsp_data, Z);
        chk1({tag, " req_val"}, htif_req_val, L);
        chk1({tag, " req_rw"}, htif_req_rw, L);
        chkw({tag, " req_addr"}, 128'(htif_req_addr), Z);
        chkw({tag, " req_data"}, htif_req_data, Z);
        chkw({tag, " req_tag"}, 128'(htif_req_tag), Z);
        chk1({tag, " proto_err"}, proto_err, L);
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;

        // single store
        tbl.push_back(mk(L, H,H,14'h10,A5, H, L,5'd0,Z, H,  H, L,L,14'h0,Z,5'd0,   L,L,Z, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, L,5'd0,Z, H,  H, H,H,14'h10,A5,5'd0, L,L,Z, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, L,5'd0,Z, H,  H, L,L,14'h0,Z,5'd0,   H,H,Z, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, L,5'd0,Z, H,  H, L,L,14'h0,Z,5'd0,   L,L,Z, L));
        // four loads, responses out of order 3,1,0,2; host must see them in tag order
        tbl.push_back(mk(H, H,L,14'h100,Z, H, L,5'd0,Z, H,  H, L,L,14'h0,Z,5'd0,   L,L,Z, L));
        tbl.push_back(mk(L, H,L,14'h101,Z, H, L,5'd0,Z, H,  H, H,L,14'h100,Z,5'd0, L,L,Z, L));
        tbl.push_back(mk(L, H,L,14'h102,Z, H, L,5'd0,Z, H,  H, H,L,14'h101,Z,5'd1, L,L,Z, L));
        tbl.push_back(mk(L, H,L,14'h103,Z, H, L,5'd0,Z, H,  H, H,L,14'h102,Z,5'd2, L,L,Z, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, L,5'd0,Z, H,  L, H,L,14'h103,Z,5'd3, L,L,Z, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, H,5'd3,128'h53, H, L, L,L,14'h0,Z,5'd0, L,L,Z, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, H,5'd1,128'h51, H, L, L,L,14'h0,Z,5'd0, L,L,Z, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, H,5'd0,128'h50, H, L, L,L,14'h0,Z,5'd0, L,L,Z, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, H,5'd2,128'h52, L, L, L,L,14'h0,Z,5'd0, H,L,128'h50, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, L,5'd0,Z, H,  L, L,L,14'h0,Z,5'd0,   H,L,128'h50, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, L,5'd0,Z, H,  H, L,L,14'h0,Z,5'd0,   H,L,128'h51, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, L,5'd0,Z, H,  H, L,L,14'h0,Z,5'd0,   H,L,128'h52, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, L,5'd0,Z, H,  H, L,L,14'h0,Z,5'd0,   H,L,128'h53, L));
        tbl.push_back(mk(L, L,L,14'h0,Z,   H, L,5'd0,Z, H,  H, L,L,14'h0,Z,5'd0,   L,L,Z, L));

        // reset state, with a command already offered
        reset = H;
        set_idle();
        cmd_val = H;
        #3;
        chk_all_zero("reset");
        set_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = L;
        tick();

        foreach (tbl[i]) begin
            if (tbl[i].pre_rst)
                do_reset();
            cmd_val = tbl[i].cv; cmd_rw = tbl[i].crw; cmd_addr = tbl[i].ca; cmd_data = tbl[i].cd;
            htif_req_rdy = tbl[i].qrdy; rsp_rdy = tbl[i].prdy;
            htif_resp_val = tbl[i].rv; htif_resp_tag = tbl[i].rt; htif_resp_data = tbl[i].rd;
            #1;
            chk1($sformatf("v%0d cmd_rdy", i), cmd_rdy, tbl[i].e_crdy);
            chk1($sformatf("v%0d req_val", i), htif_req_val, tbl[i].e_qv);
            if (tbl[i].e_qv) begin
                chk1($sformatf("v%0d req_rw", i), htif_req_rw, tbl[i].e_qrw);
                chkw($sformatf("v%0d req_addr", i), 128'(htif_req_addr), 128'(tbl[i].e_qa));
                chkw($sformatf("v%0d req_data", i), htif_req_data, tbl[i].e_qd);
                chkw($sformatf("v%0d req_tag", i), 128'(htif_req_tag), 128'(tbl[i].e_qt));
            end
            chk1($sformatf("v%0d rsp_val", i), rsp_val, tbl[i].e_pv);
            if (tbl[i].e_pv) begin
                chk1($sformatf("v%0d rsp_rw", i), rsp_rw, tbl[i].e_prw);
                chkw($sformatf("v%0d rsp_data", i), rsp_data, tbl[i].e_pd);
            end
            chk1($sformatf("v%0d proto_err", i), proto_err, tbl[i].e_perr);
            tick();
        end

        // full ROB: fifth command refused until a slot is popped
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            cmd_val = H;
            cmd_addr = 14'(32'h400 + i);
            #1;
            chk1($sformatf("fill accept %0d", i), cmd_rdy, H);
            tick();
        end
        set_idle();
        cmd_val = H;
        cmd_addr = 14'h404;
        #1;
        chk1("full cmd_rdy", cmd_rdy, L);
        chkw("full req_tag", 128'(htif_req_tag), 128'h3);
        tick();
        htif_resp_val = H; htif_resp_tag = 5'd0; htif_resp_data = 128'h99;
        #1;
        chk1("full with resp cmd_rdy", cmd_rdy, L);
        tick();
        set_idle();
        rsp_rdy = H;
        #1;
        chk1("full pop rsp_val", rsp_val, H);
        chkw("full pop rsp_data", rsp_data, 128'h99);
        chk1("full pop cmd_rdy", cmd_rdy, L);
        tick();
        rsp_rdy = L;
        cmd_val = H;
        cmd_addr = 14'h404;
        #1;
        chk1("after pop cmd_rdy", cmd_rdy, H);
        chk1("after pop rsp_val", rsp_val, L);
        tick();
        set_idle();
        #1;
        chk1("refill req_val", htif_req_val, H);
        chkw("refill req_tag", 128'(htif_req_tag), 128'h0);
        chkw("refill req_addr", 128'(htif_req_addr), 128'h404);

        // request backpressure: fields frozen, no accept while stalled
        do_reset();
        htif_req_rdy = L;
        cmd_val = H;
        cmd_addr = 14'h200;
        #1;
        chk1("bp first accept", cmd_rdy, H);
        tick();
        cmd_addr = 14'h201;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1($sformatf("bp%0d req_val", i), htif_req_val, H);
            chkw($sformatf("bp%0d req_addr", i), 128'(htif_req_addr), 128'h200);
            chkw($sformatf("bp%0d req_tag", i), 128'(htif_req_tag), 128'h0);
            chk1($sformatf("bp%0d cmd_rdy", i), cmd_rdy, L);
            tick();
        end
        htif_req_rdy = H;
        #1;
        chk1("bp release cmd_rdy", cmd_rdy, H);
        chkw("bp release req_addr", 128'(htif_req_addr), 128'h200);
        tick();
        cmd_val = L;
        #1;
        chk1("bp next req_val", htif_req_val, H);
        chkw("bp next req_addr", 128'(htif_req_addr), 128'h201);
        chkw("bp next req_tag", 128'(htif_req_tag), 128'h1);

        // unexpected tag on an idle slot, then legal traffic still completes
        do_reset();
        htif_resp_val = H; htif_resp_tag = 5'd2; htif_resp_data = 128'h1234;
        #1;
        chk1("perr before", proto_err, L);
        tick();
        htif_resp_val = L;
        #1;
        chk1("perr set", proto_err, H);
        tick();
        cmd_val = H; cmd_rw = H; cmd_addr = 14'h30; cmd_data = A5;
        #1;
        chk1("perr sticky", proto_err, H);
        tick();
        cmd_val = L;
        #1;
        chk1("perr store req_val", htif_req_val, H);
        chk1("perr store req_rw", htif_req_rw, H);
        tick();
        rsp_rdy = H;
        #1;
        chk1("perr store rsp_val", rsp_val, H);
        chk1("perr store rsp_rw", rsp_rw, H);
        chkw("perr store rsp_data", rsp_data, Z);
        tick();

        // tag with nonzero bits above the slot index is rejected, slot 0 stays pending
        do_reset();
        cmd_val = H; cmd_addr = 14'h300;
        tick();
        cmd_val = L;
        tick();
        htif_resp_val = H; htif_resp_tag = 5'h10; htif_resp_data = 128'hDEAD;
        tick();
        htif_resp_val = L;
        #1;
        chk1("hi tag perr", proto_err, H);
        chk1("hi tag rsp_val", rsp_val, L);
        tick();
        htif_resp_val = H; htif_resp_tag = 5'd0; htif_resp_data = 128'h77;
        tick();
        htif_resp_val = L;
        rsp_rdy = H;
        #1;
        chk1("hi tag legal rsp_val", rsp_val, H);
        chkw("hi tag legal rsp_data", rsp_data, 128'h77);
        tick();

        // reset mid-operation with three loads outstanding
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cmd_val = H;
            cmd_addr = 14'(32'h500 + i);
            tick();
        end
        cmd_val = H;
        cmd_addr = 14'h600;
        tick();
        #2;
        reset = H;
        #1;
        chk_all_zero("midrst");
        set_idle();
        @(posedge clk);
        #1;
        reset = L;
        tick();
        cmd_val = H; cmd_addr = 14'h600;
        #1;
        chk1("post rst accept", cmd_rdy, H);
        tick();
        cmd_val = L;
        #1;
        chk1("post rst req_val", htif_req_val, H);
        chkw("post rst req_tag", 128'(htif_req_tag), 128'h0);
        chkw("post rst req_addr", 128'(htif_req_addr), 128'h600);
        tick();
        htif_resp_val = H; htif_resp_tag = 5'd0; htif_resp_data = 128'h66;
        tick();
        htif_resp_val = L;
        rsp_rdy = H;
        #1;
        chk1("post rst rsp_val", rsp_val, H);
        chkw("post rst rsp_data", rsp_data, 128'h66);
        chk1("post rst proto_err", proto_err, L);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
